// File: rtl/hp_au_pkg.sv
// -----------------------------------------------------------------------------
// hp_au_pkg
// Shared definitions for the arithmetic unit and its issue/retire stage:
//   - AU op-code encodings (3-bit field, all eight codes used)
//   - default operand/result width
//   - encoding of the single-entry result slot state machine
// -----------------------------------------------------------------------------
package hp_au_pkg;

    // AU operation codes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_BCD = 3'b010;
    localparam logic [2:0] OP_CLA = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_SHF = 3'b111;

    // Default operand/result width shared with the AU
    localparam int HP_AU_WIDTH = 4;

    // Result slot state encoding
    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

endpackage

// File: rtl/hp_au_cmd_fifo.sv
// -----------------------------------------------------------------------------
// hp_au_cmd_fifo
// Parameterised synchronous command FIFO with a combinational head read.
// Pointers carry one extra wrap bit (modulo 2*DEPTH) so full and empty can be
// told apart without a separate counter.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   flush            synchronous clear of both pointers (wins over push/pop)
//   push, push_data  write request; ignored while full
//   pop              read request; ignored while empty
//   head_data        oldest entry, forced to zero while empty
//   full, empty      occupancy flags
//   level            number of stored entries (0..DEPTH)
// Storage is not reset; only the pointers are.
// -----------------------------------------------------------------------------
module hp_au_cmd_fifo #(
    parameter int DATA_W = 11,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              do_push_s;
    logic              do_pop_s;

    // Same slot index but different lap means the writer is a full lap ahead
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign level     = wr_ptr_r - rd_ptr_r;

    // Pointer update; flush overrides any push or pop in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage write (no reset on the data array)
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

    // Head read, zeroed when empty so downstream sees a defined value
    always_comb begin
        head_data = {DATA_W{1'b0}};
        if (!empty) begin
            head_data = mem_r[rd_ptr_r[AW-1:0]];
        end else begin
            head_data = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/hp_au_issue.sv
// -----------------------------------------------------------------------------
// hp_au_issue
// Issue/retire stage around the combinational arithmetic unit. Commands are
// accepted on a valid/ready handshake into hp_au_cmd_fifo; the FIFO head is
// driven to the AU and the AU result is captured into a single registered
// output slot with valid/ready back-pressure. One op per cycle sustained.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    synchronous clear of FIFO, slot and tag counter
//   in_valid/in_ready        command handshake (in_ready = !full)
//   in_a, in_b, in_sel       command operands and op code
//   au_a, au_b, au_sel       FIFO head to the AU (zero when empty)
//   au_result                combinational AU result
//   out_valid/out_ready      result handshake
//   out_result, out_sel      registered result and its op code
//   level                    FIFO occupancy
//   out_tag                  sequence tag of the result (HP_AU_ISSUE_TAG_EN only)
//
// Build option: define HP_AU_ISSUE_TAG_EN to carry a 4-bit push-order tag
// through the FIFO and expose it on out_tag.
// -----------------------------------------------------------------------------
module hp_au_issue
    import hp_au_pkg::*;
#(
    parameter int WIDTH = HP_AU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [2:0]             in_sel,
    output logic [WIDTH-1:0]       au_a,
    output logic [WIDTH-1:0]       au_b,
    output logic [2:0]             au_sel,
    input  logic [WIDTH-1:0]       au_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic [2:0]             out_sel,
    output logic [$clog2(DEPTH):0] level
`ifdef HP_AU_ISSUE_TAG_EN
    ,
    output logic [3:0]             out_tag
`endif
);

`ifdef HP_AU_ISSUE_TAG_EN
    localparam int ENT_W = 4 + 3 + 2 * WIDTH;
`else
    localparam int ENT_W = 3 + 2 * WIDTH;
`endif

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             issue_s;
    logic [ENT_W-1:0] push_data_s;
    logic [ENT_W-1:0] head_data_s;
    logic [0:0]       slot_state_r;
    logic [0:0]       slot_state_nxt_s;
    logic [WIDTH-1:0] result_r;
    logic [2:0]       sel_r;

    assign in_ready = !full_s;
    assign push_s   = in_valid && !full_s;
    // Issue whenever the slot is free or being drained this cycle
    assign issue_s  = !empty_s && (!out_valid || out_ready);

    hp_au_cmd_fifo #(
        .DATA_W (ENT_W),
        .DEPTH  (DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (issue_s),
        .head_data (head_data_s),
        .full      (full_s),
        .empty     (empty_s),
        .level     (level)
    );

    // FIFO entry layout: {[tag,] sel, a, b}
    assign au_b   = head_data_s[WIDTH-1:0];
    assign au_a   = head_data_s[2*WIDTH-1:WIDTH];
    assign au_sel = head_data_s[2*WIDTH+2:2*WIDTH];

`ifdef HP_AU_ISSUE_TAG_EN
    logic [3:0] tag_cnt_r;
    logic [3:0] tag_r;

    assign push_data_s = {tag_cnt_r, in_sel, in_a, in_b};
    assign out_tag     = tag_r;

    // Sequence tag counter, advanced per accepted command, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_cnt_r <= 4'd0;
        end else if (flush) begin
            tag_cnt_r <= 4'd0;
        end else if (push_s) begin
            tag_cnt_r <= tag_cnt_r + 4'd1;
        end else begin
            tag_cnt_r <= tag_cnt_r;
        end
    end

    // Slot copy of the issued command's tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_r <= 4'd0;
        end else if (flush) begin
            tag_r <= 4'd0;
        end else if (issue_s) begin
            tag_r <= head_data_s[2*WIDTH+6:2*WIDTH+3];
        end else begin
            tag_r <= tag_r;
        end
    end
`else
    assign push_data_s = {in_sel, in_a, in_b};
`endif

    assign out_valid  = (slot_state_r == SLOT_FULL);
    assign out_result = result_r;
    assign out_sel    = sel_r;

    // Slot next-state: stays full across issue-with-drain and stalls
    always_comb begin
        slot_state_nxt_s = slot_state_r;
        case (slot_state_r)
            SLOT_EMPTY: begin
                if (issue_s) begin
                    slot_state_nxt_s = SLOT_FULL;
                end else begin
                    slot_state_nxt_s = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (issue_s) begin
                    slot_state_nxt_s = SLOT_FULL;
                end else if (out_ready) begin
                    slot_state_nxt_s = SLOT_EMPTY;
                end else begin
                    slot_state_nxt_s = SLOT_FULL;
                end
            end
            default: begin
                slot_state_nxt_s = SLOT_EMPTY;
            end
        endcase
    end

    // Slot state and payload; payload only changes on issue so stalls hold it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_state_r <= SLOT_EMPTY;
            result_r     <= {WIDTH{1'b0}};
            sel_r        <= 3'b000;
        end else if (flush) begin
            slot_state_r <= SLOT_EMPTY;
            result_r     <= {WIDTH{1'b0}};
            sel_r        <= 3'b000;
        end else begin
            slot_state_r <= slot_state_nxt_s;
            if (issue_s) begin
                result_r <= au_result;
                sel_r    <= au_sel;
            end else begin
                result_r <= result_r;
                sel_r    <= sel_r;
            end
        end
    end

endmodule

// File: tb/tb_hp_au_issue.sv
// -----------------------------------------------------------------------------
// tb_hp_au_issue
// Directed scoreboard bench for hp_au_issue. A small behavioural AU closes the
// au_* -> au_result loop. Accepted commands push hand-computed expected
// results into a queue; a monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_hp_au_issue;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_sel;
    logic [3:0] au_a;
    logic [3:0] au_b;
    logic [2:0] au_sel;
    logic [3:0] au_result;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_result;
    logic [2:0] out_sel;
    logic [2:0] level;
`ifdef HP_AU_ISSUE_TAG_EN
    logic [3:0] out_tag;
`endif

    typedef struct packed {
        logic [3:0] res;
        logic [2:0] sel;
        logic [3:0] tag;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [3:0] exp_tag;
    int         checks;
    int         errors;
    logic       track_lvl;
    logic [2:0] max_lvl;

    hp_au_issue #(
        .WIDTH (4),
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sel     (in_sel),
        .au_a       (au_a),
        .au_b       (au_b),
        .au_sel     (au_sel),
        .au_result  (au_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sel    (out_sel),
        .level      (level)
`ifdef HP_AU_ISSUE_TAG_EN
        ,
        .out_tag    (out_tag)
`endif
    );

    // Behavioural stand-in for the combinational AU
    function automatic logic [3:0] au_model(input logic [3:0] a, input logic [3:0] b,
                                            input logic [2:0] s);
        case (s)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a + b;
            3'b011:  return a + b;
            3'b100:  return a & b;
            3'b101:  return a | b;
            3'b110:  return a ^ b;
            default: return {a[2:0], 1'b0};
        endcase
    endfunction

    assign au_result = au_model(au_a, au_b, au_sel);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Offer one command (called right after a falling edge); record it once accepted
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                        input logic [3:0] res);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sel   = sel;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t = t + 1;
        end
        chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        if (in_ready) begin
            exp_q.push_back('{res: res, sel: sel, tag: exp_tag});
            exp_tag = exp_tag + 4'd1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((level != 3'd0 || out_valid) && t < 200) begin
            @(negedge clk);
            t = t + 1;
        end
        chk({name, "_drained"}, {31'd0, (level == 3'd0 && !out_valid)}, 32'd1);
        chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
    endtask

    // Scenario 1 body: single ADD 3+5, checks two-edge latency
    task automatic scen_add(input string name);
        out_ready = 1'b1;
        send(4'd3, 4'd5, 3'b000, 4'd8);
        chk({name, "_valid_early"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_level"}, {29'd0, level}, 32'd1);
        @(negedge clk);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_result"}, {28'd0, out_result}, 32'd8);
        chk({name, "_sel"}, {29'd0, out_sel}, 32'd0);
        wait_drain(name);
    endtask

    // Scoreboard monitor: compares whenever a result handshake will complete
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_result", {28'd0, out_result}, {28'd0, mon_e.res});
                chk("out_sel", {29'd0, out_sel}, {29'd0, mon_e.sel});
`ifdef HP_AU_ISSUE_TAG_EN
                chk("out_tag", {28'd0, out_tag}, {28'd0, mon_e.tag});
`endif
            end
        end
    end

    // Peak FIFO occupancy while tracking is enabled
    always @(negedge clk) begin
        if (track_lvl && level > max_lvl) begin
            max_lvl = level;
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        exp_tag   = 4'd0;
        track_lvl = 1'b0;
        max_lvl   = 3'd0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 4'd0;
        in_b      = 4'd0;
        in_sel    = 3'b000;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", {28'd0, out_result}, 32'd0);
        chk("rst_out_sel", {29'd0, out_sel}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_au", {21'd0, au_a, au_b, au_sel}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single ADD
        scen_add("s1");

        // 2: back-to-back SUB, AND, XOR with consumer always ready
        max_lvl   = 3'd0;
        track_lvl = 1'b1;
        send(4'd9, 4'd4, 3'b001, 4'd5);
        send(4'hC, 4'hA, 3'b100, 4'd8);
        send(4'd6, 4'd3, 3'b110, 4'd5);
        chk("s2_res_and", {28'd0, out_result}, 32'd8);
        @(negedge clk);
        chk("s2_res_xor", {28'd0, out_result}, 32'd5);
        chk("s2_valid_xor", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        chk("s2_valid_done", {31'd0, out_valid}, 32'd0);
        track_lvl = 1'b0;
        chk("s2_max_level", {29'd0, max_lvl}, 32'd1);
        wait_drain("s2");

        // 3: stalled consumer, DEPTH+1 accepted, then overflow attempt
        out_ready = 1'b0;
        send(4'd1, 4'd1, 3'b000, 4'd2);
        send(4'd2, 4'd2, 3'b000, 4'd4);
        send(4'd5, 4'd2, 3'b101, 4'd7);
        send(4'd3, 4'd1, 3'b001, 4'd2);
        send(4'hF, 4'd1, 3'b110, 4'hE);
        chk("s3_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("s3_level_full", {29'd0, level}, 32'd4);
        chk("s3_slot_valid", {31'd0, out_valid}, 32'd1);
        chk("s3_slot_first", {28'd0, out_result}, 32'd2);
        in_valid = 1'b1;
        in_a     = 4'd3;
        in_b     = 4'd3;
        in_sel   = 3'b100;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("s3_level_held", {29'd0, level}, 32'd4);
        chk("s3_slot_held", {28'd0, out_result}, 32'd2);
        out_ready = 1'b1;
        wait_drain("s3");

        // 4: 20 commands across pointer and tag wrap
        flush = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        exp_tag = 4'd0;
        for (int i = 0; i < 20; i++) begin
            logic [3:0] a4;
            a4 = i[3:0];
            send(a4, 4'd1, 3'b000, a4 + 4'd1);
        end
        wait_drain("s4");

        // 5: flush with FIFO full and a simultaneous push
        out_ready = 1'b0;
        send(4'd1, 4'd2, 3'b000, 4'd3);
        send(4'd2, 4'd2, 3'b000, 4'd4);
        send(4'd3, 4'd2, 3'b000, 4'd5);
        send(4'd4, 4'd2, 3'b000, 4'd6);
        send(4'd5, 4'd2, 3'b000, 4'd7);
        chk("s5_full", {29'd0, level}, 32'd4);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_a     = 4'd7;
        in_b     = 4'd7;
        in_sel   = 3'b000;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        exp_tag = 4'd0;
        chk("s5_level", {29'd0, level}, 32'd0);
        chk("s5_out_valid", {31'd0, out_valid}, 32'd0);
        chk("s5_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("s5_no_output", {31'd0, out_valid}, 32'd0);

        // 6: asynchronous reset with slot full and level 3
        out_ready = 1'b0;
        send(4'd1, 4'd2, 3'b000, 4'd3);
        send(4'd2, 4'd2, 3'b000, 4'd4);
        send(4'd3, 4'd2, 3'b000, 4'd5);
        send(4'd4, 4'd2, 3'b000, 4'd6);
        chk("s6_pre_level", {29'd0, level}, 32'd3);
        chk("s6_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_async_valid", {31'd0, out_valid}, 32'd0);
        chk("s6_async_level", {29'd0, level}, 32'd0);
        chk("s6_async_ready", {31'd0, in_ready}, 32'd1);
        chk("s6_async_result", {25'd0, out_result, out_sel}, 32'd0);
        chk("s6_async_au", {21'd0, au_a, au_b, au_sel}, 32'd0);
        exp_q.delete();
        exp_tag = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        scen_add("s6_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
